// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 64;

  // Sequencer state: normal flow or frozen on a data-memory access.
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Control bits carried by the ID/EX, EX/MEM and MEM/WB registers.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
  } stage_ctrl_t;

  // Canonical NOP (addi x0, x0, 0) loaded into IF/ID on a flush.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Bubble: every side-effecting control bit cleared.
  localparam stage_ctrl_t BUBBLE_CTRL = '0;

  // True when a load's destination feeds a source of the next instruction; x0 never does.
  function automatic logic hazard_match(input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] rs1,
                                        input logic [REG_W-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value
);

  // Count up on inc, hold at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: memory freeze, branch flush, load-use bubble.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             mem_branch_taken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             pc_src,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             dmem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned        WAIT_W    = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              err_nxt;
  logic              acc;
  logic              frozen;
  logic              timeout;

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      dmem_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      dmem_err <= err_nxt;
    end
  end

  // Next state and pipeline controls; priority is freeze > branch > load-use.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    err_nxt       = dmem_err;
    acc           = mem_memread | mem_memwrite;
    frozen        = 1'b0;
    timeout       = 1'b0;
    dmem_req      = 1'b0;
    pc_en         = 1'b1;
    pc_src        = 1'b0;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;

    if (!reset) begin
      case (state)
        RUN: begin
          if (acc) begin
            dmem_req = 1'b1;
            if (!dmem_ready) begin
              frozen       = 1'b1;
              state_nxt    = WAIT;
              wait_cnt_nxt = WAIT_W'(1);
            end
          end
        end
        WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout      = 1'b1;
            err_nxt      = 1'b1;
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else begin
            frozen       = 1'b1;
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      endcase

      if (frozen) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else begin
        // A timed-out access releases the pipe but its data is discarded.
        if (timeout) mem_wb_bubble = 1'b1;
        if (mem_branch_taken) begin
          pc_src       = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (ex_memread && hazard_match(ex_rd, id_rs1, id_rs2)) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  // Cycles with the PC held.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_en),
    .clear (1'b0),
    .value (stall_cnt)
  );

  // Branch-taken flush events.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_src),
    .clear (1'b0),
    .value (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus reset/saturation sequences.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned NVEC     = 25;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_memread, mem_memread, mem_memwrite, mem_branch_taken, dmem_ready;
  logic dmem_req, pc_en, pc_src, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, ex_mem_flush, mem_wb_bubble, dmem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic dmem_req, pc_en, pc_src, if_id_en, if_id_flush;
    logic id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_bubble;
  } ctrl_t;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic ld_ex, ld_mem, st_mem, br, rdy;
  } stim_t;

  typedef struct packed {
    stim_t in;
    ctrl_t exp;
    logic  err;
  } vec_t;

  localparam ctrl_t C_IDLE = 10'b0101010100;
  localparam ctrl_t C_FRZ  = 10'b1000000001;
  localparam ctrl_t C_ACC  = 10'b1101010100;
  localparam ctrl_t C_LU   = 10'b0000011100;
  localparam ctrl_t C_BR   = 10'b0111111110;
  localparam ctrl_t C_BRR  = 10'b1111111110;
  localparam ctrl_t C_TOR  = 10'b1101010101;

  ctrl_t act;
  ctrl_t exp_q[$];
  vec_t  tbl[NVEC];
  int    checks = 0;
  int    errors = 0;
  int    stall_m = 0;
  int    flush_m = 0;

  assign act = {dmem_req, pc_en, pc_src, if_id_en, if_id_flush,
                id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_bubble};

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .ex_rd            (ex_rd),
    .ex_memread       (ex_memread),
    .mem_memread      (mem_memread),
    .mem_memwrite     (mem_memwrite),
    .mem_branch_taken (mem_branch_taken),
    .dmem_ready       (dmem_ready),
    .dmem_req         (dmem_req),
    .pc_en            (pc_en),
    .pc_src           (pc_src),
    .if_id_en         (if_id_en),
    .if_id_flush      (if_id_flush),
    .id_ex_en         (id_ex_en),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_en        (ex_mem_en),
    .ex_mem_flush     (ex_mem_flush),
    .mem_wb_bubble    (mem_wb_bubble),
    .dmem_err         (dmem_err),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input int rs1, input int rs2, input int rd,
                               input logic lde, input logic ldm, input logic stm,
                               input logic br, input logic rdy);
    stim_t s;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    s.ld_ex = lde; s.ld_mem = ldm; s.st_mem = stm; s.br = br; s.rdy = rdy;
    return s;
  endfunction

  function automatic vec_t mk(input stim_t s, input ctrl_t c, input logic e);
    vec_t v;
    v.in = s; v.exp = c; v.err = e;
    return v;
  endfunction

  task automatic apply(input stim_t s);
    id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
    ex_memread = s.ld_ex; mem_memread = s.ld_mem; mem_memwrite = s.st_mem;
    mem_branch_taken = s.br; dmem_ready = s.rdy;
  endtask

  // Pop the oldest expected control word and compare it with the live outputs.
  task automatic check_ctrl(input string name);
    ctrl_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b", name, act, e);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    stim_t idle;
    stim_t lu;
    idle = st(0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(idle,                       C_IDLE, 1'b0);
    tbl[1]  = mk(st(1, 5, 5, 1, 0, 0, 0, 0), C_LU,   1'b0);
    tbl[2]  = mk(st(1, 5, 5, 0, 0, 0, 0, 0), C_IDLE, 1'b0);
    tbl[3]  = mk(st(0, 0, 0, 1, 0, 0, 0, 0), C_IDLE, 1'b0);
    tbl[4]  = mk(st(7, 2, 7, 1, 0, 0, 0, 0), C_LU,   1'b0);
    tbl[5]  = mk(st(3, 4, 7, 1, 0, 0, 0, 0), C_IDLE, 1'b0);
    tbl[6]  = mk(st(0, 0, 0, 0, 0, 1, 0, 1), C_ACC,  1'b0);
    tbl[7]  = mk(idle,                       C_IDLE, 1'b0);
    tbl[8]  = mk(st(0, 0, 0, 0, 1, 0, 0, 0), C_FRZ,  1'b0);
    tbl[9]  = mk(st(0, 0, 0, 0, 1, 0, 0, 0), C_FRZ,  1'b0);
    tbl[10] = mk(st(0, 0, 0, 0, 1, 0, 0, 0), C_FRZ,  1'b0);
    tbl[11] = mk(st(0, 0, 0, 0, 1, 0, 0, 1), C_ACC,  1'b0);
    tbl[12] = mk(idle,                       C_IDLE, 1'b0);
    tbl[13] = mk(st(0, 0, 0, 0, 0, 0, 1, 0), C_BR,   1'b0);
    tbl[14] = mk(st(6, 6, 6, 1, 1, 0, 1, 0), C_FRZ,  1'b0);
    tbl[15] = mk(st(6, 6, 6, 1, 1, 0, 1, 0), C_FRZ,  1'b0);
    tbl[16] = mk(st(6, 6, 6, 1, 1, 0, 1, 1), C_BRR,  1'b0);
    tbl[17] = mk(idle,                       C_IDLE, 1'b0);
    tbl[18] = mk(st(0, 0, 0, 0, 1, 0, 0, 0), C_FRZ,  1'b0);
    tbl[19] = mk(st(0, 0, 0, 0, 1, 0, 0, 0), C_FRZ,  1'b0);
    tbl[20] = mk(st(0, 0, 0, 0, 1, 0, 0, 0), C_FRZ,  1'b0);
    tbl[21] = mk(st(0, 0, 0, 0, 1, 0, 0, 0), C_TOR,  1'b0);
    tbl[22] = mk(idle,                       C_IDLE, 1'b1);
    tbl[23] = mk(st(9, 1, 9, 1, 0, 0, 0, 0), C_LU,   1'b1);
    tbl[24] = mk(idle,                       C_IDLE, 1'b1);

    // Reset held with busy inputs: outputs must look like idle RUN.
    reset = 1'b1;
    apply(st(5, 5, 5, 1, 1, 0, 1, 0));
    #2;
    exp_q.push_back(C_IDLE);
    check_ctrl("reset_hold");
    check_val("reset_stall", 32'(stall_cnt), 0);
    check_val("reset_flush", 32'(flush_cnt), 0);
    check_val("reset_err", 32'(dmem_err), 0);
    apply(idle);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table: one cycle per row, counters checked against a running model.
    for (int i = 0; i < int'(NVEC); i++) begin
      apply(tbl[i].in);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      check_ctrl($sformatf("vec%0d", i));
      check_val($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(stall_m));
      check_val($sformatf("vec%0d_flush", i), 32'(flush_cnt), 32'(flush_m));
      check_val($sformatf("vec%0d_err", i), 32'(dmem_err), 32'(tbl[i].err));
      if (!tbl[i].exp.pc_en && stall_m < int'(CMAX)) stall_m++;
      if (tbl[i].exp.pc_src && flush_m < int'(CMAX)) flush_m++;
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a WAIT.
    apply(st(0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_val("midwait_stall", 32'(stall_cnt), 0);
    check_val("midwait_flush", 32'(flush_cnt), 0);
    check_val("midwait_err", 32'(dmem_err), 0);
    check_val("midwait_req", 32'(dmem_req), 0);
    apply(idle);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.push_back(C_IDLE);
    check_ctrl("post_reset_run");
    @(posedge clk); #1;

    // Continuous load-use: stall counter must saturate at all-ones.
    lu = st(4, 0, 4, 1, 0, 0, 0, 0);
    apply(lu);
    exp_q.push_back(C_LU);
    @(negedge clk);
    check_ctrl("sat_lu");
    repeat (20) @(posedge clk);
    #1;
    check_val("stall_sat", 32'(stall_cnt), 32'(CMAX));

    // Continuous branch: flush counter saturates, stall counter holds.
    apply(st(0, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(C_BR);
    @(negedge clk);
    check_ctrl("sat_br");
    repeat (20) @(posedge clk);
    #1;
    check_val("flush_sat", 32'(flush_cnt), 32'(CMAX));
    check_val("stall_hold", 32'(stall_cnt), 32'(CMAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
